// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine with registered state and decodes.
// Optional `JTAG_TAP_RTI_CNT_EN adds a saturating Run-Test/Idle cycle counter.
module jtag_tap_fsm #(
  parameter int unsigned RTI_CNT_W = 16
) (
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output logic [3:0] state,
  output logic       reset,
  output logic       capir,
  output logic       shiftir,
  output logic       updateir,
  output logic       capdr,
  output logic       shiftdr,
  output logic       updatedr,
  output logic       runidle,
  output logic       tdo_en
`ifdef JTAG_TAP_RTI_CNT_EN
  ,
  output logic [RTI_CNT_W-1:0] rti_count
`endif
);

  typedef enum logic [3:0] {
    TLR     = 4'hF,
    RTI     = 4'hC,
    SELDR   = 4'h7,
    CAPDR   = 4'h6,
    SHDR    = 4'h2,
    EX1DR   = 4'h1,
    PAUSEDR = 4'h3,
    EX2DR   = 4'h0,
    UPDDR   = 4'h5,
    SELIR   = 4'h4,
    CAPIR   = 4'hE,
    SHIR    = 4'hA,
    EX1IR   = 4'h9,
    PAUSEIR = 4'hB,
    EX2IR   = 4'h8,
    UPDIR   = 4'hD
  } tap_e;

  tap_e state_q;
  tap_e state_d;

  if (RTI_CNT_W < 1) begin : g_bad_w
    $error("RTI_CNT_W must be at least 1");
  end

  always_ff @(posedge tck) begin
    if (trst) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:     state_d = tms ? TLR     : RTI;
      RTI:     state_d = tms ? SELDR   : RTI;
      SELDR:   state_d = tms ? SELIR   : CAPDR;
      CAPDR:   state_d = tms ? EX1DR   : SHDR;
      SHDR:    state_d = tms ? EX1DR   : SHDR;
      EX1DR:   state_d = tms ? UPDDR   : PAUSEDR;
      PAUSEDR: state_d = tms ? EX2DR   : PAUSEDR;
      EX2DR:   state_d = tms ? UPDDR   : SHDR;
      UPDDR:   state_d = tms ? SELDR   : RTI;
      SELIR:   state_d = tms ? TLR     : CAPIR;
      CAPIR:   state_d = tms ? EX1IR   : SHIR;
      SHIR:    state_d = tms ? EX1IR   : SHIR;
      EX1IR:   state_d = tms ? UPDIR   : PAUSEIR;
      PAUSEIR: state_d = tms ? EX2IR   : PAUSEIR;
      EX2IR:   state_d = tms ? UPDIR   : SHIR;
      UPDIR:   state_d = tms ? SELDR   : RTI;
      default: state_d = TLR;
    endcase
  end

  // Decodes look only at the state register so they never glitch with tms.
  always_comb begin
    reset    = 1'b0;
    capir    = 1'b0;
    shiftir  = 1'b0;
    updateir = 1'b0;
    capdr    = 1'b0;
    shiftdr  = 1'b0;
    updatedr = 1'b0;
    runidle  = 1'b0;
    unique case (state_q)
      TLR:     reset    = 1'b1;
      CAPIR:   capir    = 1'b1;
      SHIR:    shiftir  = 1'b1;
      UPDIR:   updateir = 1'b1;
      CAPDR:   capdr    = 1'b1;
      SHDR:    shiftdr  = 1'b1;
      UPDDR:   updatedr = 1'b1;
      RTI:     runidle  = 1'b1;
      default: ;
    endcase
  end

  assign tdo_en = shiftir | shiftdr;
  assign state  = state_q;

`ifdef JTAG_TAP_RTI_CNT_EN
  logic [RTI_CNT_W-1:0] rti_count_q;
  logic [RTI_CNT_W-1:0] rti_count_d;

  always_comb begin
    rti_count_d = rti_count_q;
    if (state_q != RTI && state_d == RTI) begin
      rti_count_d = '0;
    end else if (state_q == RTI && state_d == RTI) begin
      if (rti_count_q != '1) begin
        rti_count_d = rti_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge tck) begin
    if (trst) begin
      rti_count_q <= '0;
    end else begin
      rti_count_q <= rti_count_d;
    end
  end

  assign rti_count = rti_count_q;
`endif

endmodule

// File: tb/tb_jtag_tap_fsm.sv
// Directed bench for jtag_tap_fsm: transitions, decodes, trst and TLR recovery.
// Define JTAG_TAP_RTI_CNT_EN in both builds to also exercise the RTI counter.
module tb_jtag_tap_fsm;

  logic       tck;
  logic       trst;
  logic       tms;
  logic [3:0] state;
  logic       reset;
  logic       capir;
  logic       shiftir;
  logic       updateir;
  logic       capdr;
  logic       shiftdr;
  logic       updatedr;
  logic       runidle;
  logic       tdo_en;
`ifdef JTAG_TAP_RTI_CNT_EN
  logic [3:0] rti_count;
`endif

  int n_cmp;
  int n_err;

  jtag_tap_fsm #(
    .RTI_CNT_W(4)
  ) dut (
    .tck      (tck),
    .trst     (trst),
    .tms      (tms),
    .state    (state),
    .reset    (reset),
    .capir    (capir),
    .shiftir  (shiftir),
    .updateir (updateir),
    .capdr    (capdr),
    .shiftdr  (shiftdr),
    .updatedr (updatedr),
    .runidle  (runidle),
    .tdo_en   (tdo_en)
`ifdef JTAG_TAP_RTI_CNT_EN
    ,
    .rti_count(rti_count)
`endif
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  // {reset,capir,shiftir,updateir,capdr,shiftdr,updatedr,runidle,tdo_en}
  function automatic logic [8:0] exp_dec(input logic [3:0] s);
    case (s)
      4'hF:    return 9'b1_0000000_0;
      4'hE:    return 9'b0_1000000_0;
      4'hA:    return 9'b0_0100000_1;
      4'hD:    return 9'b0_0010000_0;
      4'h6:    return 9'b0_0001000_0;
      4'h2:    return 9'b0_0000100_1;
      4'h5:    return 9'b0_0000010_0;
      4'hC:    return 9'b0_0000001_0;
      default: return 9'b0_0000000_0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [3:0] exp_s);
    logic [8:0] dec;
    dec = {reset, capir, shiftir, updateir, capdr,
           shiftdr, updatedr, runidle, tdo_en};
    chk({tag, ".state"}, 32'(state), 32'(exp_s));
    chk({tag, ".dec"}, 32'(dec), 32'(exp_dec(exp_s)));
  endtask

  task automatic step(input logic r, input logic m);
    @(negedge tck);
    trst = r;
    tms  = m;
    @(posedge tck);
    #1;
  endtask

  logic [7:0] path [16];
  int         plen [16];
  logic [3:0] ptgt [16];

  initial begin
    n_cmp = 0;
    n_err = 0;
    trst  = 1'b1;
    tms   = 1'b0;

    // paths from TLR, bit i is the i-th tms value
    ptgt[0]  = 4'hF; path[0]  = 8'b0;        plen[0]  = 0;
    ptgt[1]  = 4'hC; path[1]  = 8'b0;        plen[1]  = 1;
    ptgt[2]  = 4'h7; path[2]  = 8'b10;       plen[2]  = 2;
    ptgt[3]  = 4'h6; path[3]  = 8'b010;      plen[3]  = 3;
    ptgt[4]  = 4'h2; path[4]  = 8'b0010;     plen[4]  = 4;
    ptgt[5]  = 4'h1; path[5]  = 8'b1010;     plen[5]  = 4;
    ptgt[6]  = 4'h3; path[6]  = 8'b01010;    plen[6]  = 5;
    ptgt[7]  = 4'h0; path[7]  = 8'b101010;   plen[7]  = 6;
    ptgt[8]  = 4'h5; path[8]  = 8'b11010;    plen[8]  = 5;
    ptgt[9]  = 4'h4; path[9]  = 8'b110;      plen[9]  = 3;
    ptgt[10] = 4'hE; path[10] = 8'b0110;     plen[10] = 4;
    ptgt[11] = 4'hA; path[11] = 8'b00110;    plen[11] = 5;
    ptgt[12] = 4'h9; path[12] = 8'b10110;    plen[12] = 5;
    ptgt[13] = 4'hB; path[13] = 8'b010110;   plen[13] = 6;
    ptgt[14] = 4'h8; path[14] = 8'b1010110;  plen[14] = 7;
    ptgt[15] = 4'hD; path[15] = 8'b110110;   plen[15] = 6;

    // reset state
    step(1'b1, 1'b0);
    chk_st("rst", 4'hF);
    step(1'b1, 1'b1);
    chk_st("rst_hold_tms1", 4'hF);
    step(1'b1, 1'b0);
    chk_st("rst_hold_tms0", 4'hF);
    step(1'b0, 1'b0);
    chk_st("rst_release", 4'hC);

    // IR capture/shift entry from TLR
    step(1'b1, 1'b0);
    step(1'b0, 1'b0); chk_st("ir0", 4'hC);
    step(1'b0, 1'b1); chk_st("ir1", 4'h7);
    step(1'b0, 1'b1); chk_st("ir2", 4'h4);
    step(1'b0, 1'b0); chk_st("ir3", 4'hE);
    step(1'b0, 1'b0); chk_st("ir4", 4'hA);
    step(1'b0, 1'b0); chk_st("ir_shift_hold", 4'hA);

    // IR exit/pause/update path
    step(1'b0, 1'b1); chk_st("irx0", 4'h9);
    step(1'b0, 1'b0); chk_st("irx1", 4'hB);
    step(1'b0, 1'b1); chk_st("irx2", 4'h8);
    step(1'b0, 1'b0); chk_st("irx3", 4'hA);
    step(1'b0, 1'b1); chk_st("irx4", 4'h9);
    step(1'b0, 1'b1); chk_st("irx5", 4'hD);
    step(1'b0, 1'b0); chk_st("irx6", 4'hC);

    // DR path from RTI
    step(1'b0, 1'b1); chk_st("dr0", 4'h7);
    step(1'b0, 1'b0); chk_st("dr1", 4'h6);
    step(1'b0, 1'b0); chk_st("dr2", 4'h2);
    step(1'b0, 1'b0); chk_st("dr3", 4'h2);
    step(1'b0, 1'b1); chk_st("dr4", 4'h1);
    step(1'b0, 1'b1); chk_st("dr5", 4'h5);
    step(1'b0, 1'b0); chk_st("dr6", 4'hC);

    // DR pause/exit2 loop and update->SELDR
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    chk_st("drp0", 4'h1);
    step(1'b0, 1'b0); chk_st("drp1", 4'h3);
    step(1'b0, 1'b0); chk_st("drp2", 4'h3);
    step(1'b0, 1'b1); chk_st("drp3", 4'h0);
    step(1'b0, 1'b1); chk_st("drp4", 4'h5);
    step(1'b0, 1'b1); chk_st("drp5", 4'h7);

    // trst for one cycle mid-shift overrides tms
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    chk_st("pre_trst_shdr", 4'h2);
    step(1'b1, 1'b0);
    chk_st("trst_from_shdr", 4'hF);
    chk("trst_from_shdr.tdo_en", 32'(tdo_en), 32'd0);
    step(1'b0, 1'b1);
    chk_st("tlr_after_trst", 4'hF);

    // every state recovers to TLR within 5 tms=1 cycles
    for (int s = 0; s < 16; s++) begin
      logic [7:0] p;
      p = path[s];
      step(1'b1, 1'b0);
      for (int k = 0; k < plen[s]; k++) begin
        step(1'b0, p[k]);
      end
      chk($sformatf("reach_%0h", ptgt[s]), 32'(state), 32'(ptgt[s]));
      for (int k = 0; k < 5; k++) begin
        step(1'b0, 1'b1);
      end
      chk_st($sformatf("tlr5_from_%0h", ptgt[s]), 4'hF);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk_st($sformatf("tlr_hold_%0h", ptgt[s]), 4'hF);
    end

`ifdef JTAG_TAP_RTI_CNT_EN
    step(1'b1, 1'b0);
    chk("cnt_rst", 32'(rti_count), 32'd0);
    step(1'b0, 1'b0);
    chk("cnt_enter", 32'(rti_count), 32'd0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    chk("cnt_3", 32'(rti_count), 32'd3);
    for (int k = 0; k < 17; k++) step(1'b0, 1'b0);
    chk("cnt_sat", 32'(rti_count), 32'd15);
    step(1'b0, 1'b1);
    chk_st("cnt_exit", 4'h7);
    chk("cnt_hold_seldr", 32'(rti_count), 32'd15);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("cnt_hold_upddr", 32'(rti_count), 32'd15);
    step(1'b0, 1'b0);
    chk_st("cnt_reenter", 4'hC);
    chk("cnt_reenter_clr", 32'(rti_count), 32'd0);
    step(1'b0, 1'b0);
    chk("cnt_after_1", 32'(rti_count), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtag_tap_fsm.md
JTAG_TAP_FSM -- requirements
Module: jtag_tap_fsm

Interface
REQ-001 SHALL have parameter RTI_CNT_W, default 16, width of the Run-Test/Idle cycle counter (used only when JTAG_TAP_RTI_CNT_EN is defined).
REQ-002 SHALL have port tck  input  1  test clock; all state updates on posedge tck.
REQ-003 SHALL have port trst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port tms  input  1  test mode select, sampled on posedge tck.
REQ-005 SHALL have port state  output  4  current TAP state encoding (REQ-010).
REQ-006 SHALL have port reset  output  1  high while in Test-Logic-Reset; feeds the instruction register's reset input.
REQ-007 SHALL have ports capir, shiftir, updateir  output  1 each  high in Capture-IR, Shift-IR, Update-IR respectively; feed the instruction register.
REQ-008 SHALL have ports capdr, shiftdr, updatedr, runidle  output  1 each  high in Capture-DR, Shift-DR, Update-DR, Run-Test/Idle respectively.
REQ-009 SHALL have port tdo_en  output  1  high in Shift-IR or Shift-DR.

Function
REQ-010 SHALL use state encoding: TLR=F, RTI=C, SELDR=7, CAPDR=6, SHDR=2, EX1DR=1, PAUSEDR=3, EX2DR=0, UPDDR=5, SELIR=4, CAPIR=E, SHIR=A, EX1IR=9, PAUSEIR=B, EX2IR=8, UPDIR=D.
REQ-011 SHALL transition on each posedge tck per (tms=0 / tms=1): TLR->RTI/TLR; RTI->RTI/SELDR; SELDR->CAPDR/SELIR; SELIR->CAPIR/TLR.
REQ-012 SHALL transition, DR column (IR column identical with IR states): CAP->SH/EX1; SH->SH/EX1; EX1->PAUSE/UPD; PAUSE->PAUSE/EX2; EX2->SH/UPD; UPD->RTI/SELDR.
REQ-013 SHALL decode all decode outputs (REQ-006..009) combinationally from the state register only, never from tms; zero added latency relative to state.
REQ-014 SHALL assert exactly one of reset/capir/shiftir/updateir/capdr/shiftdr/updatedr/runidle, or none, in any cycle (one-hot-or-zero).
REQ-015 SHALL reach TLR from any state within 5 consecutive tck cycles with tms=1.
REQ-016 SHALL hold TLR indefinitely while tms=1, keeping reset=1.
REQ-017 SHALL treat the 4-bit state as fully decoded; no unreachable encodings exist.

Reset
REQ-018 SHALL, when trst=1 at posedge tck, load state=TLR, overriding tms, in every state including mid-shift.
REQ-019 SHALL present after reset: state=4'hF, reset=1, all other decode outputs 0, tdo_en=0.
REQ-020 SHALL, with trst held high, remain in TLR regardless of tms; first tms-driven transition occurs on the first posedge after trst falls.

Configuration
REQ-021 SHALL, when macro JTAG_TAP_RTI_CNT_EN is defined, add output rti_count [RTI_CNT_W-1:0]: count of completed tck cycles in RTI.
REQ-022 SHALL, with JTAG_TAP_RTI_CNT_EN, clear rti_count to 0 on trst and on every posedge at which state enters RTI from a non-RTI state; increment by 1 on each posedge with state=RTI and next state=RTI; saturate at all-ones; hold value in other states.
REQ-023 SHALL, without JTAG_TAP_RTI_CNT_EN, omit port rti_count and its counter logic entirely; all other behaviour unchanged.

Verification
REQ-024 SHALL cover: trst=1 for 1 cycle from SHDR -> state=F, reset=1, tdo_en=0 next cycle.
REQ-025 SHALL cover: from TLR, tms sequence 0,1,1,0,0 -> states C,7,4,E,A; capir=1 in E; shiftir=1 and tdo_en=1 in A.
REQ-026 SHALL cover: from SHIR, tms 1,0,1,0,1,1,0 -> 9,B,8,A,9,D,C; updateir=1 only in D.
REQ-027 SHALL cover: from each of the 16 states, 5 cycles tms=1 -> state=F; further tms=1 keeps F.
REQ-028 SHALL cover: DR path from RTI, tms 1,0,0,0,1,1,0 -> 7,6,2,2,1,5,C; capdr/shiftdr/updatedr pulses in 6/2/5.
REQ-029 SHALL cover (JTAG_TAP_RTI_CNT_EN, RTI_CNT_W=4): 20 cycles in RTI -> rti_count saturates at 15; exit via SELDR, re-enter RTI -> rti_count=0.
